// File: rtl/gnrc_lzc_pipe.sv
// Elastic leading/trailing zero counter: count is formed on the input side, then rides STAGES valid/ready slots.
// Latency STAGES cycles unstalled; a full pipe with ready_i low drops ready_o. GNRC_LZC_PIPE_THERM_EN adds therm_o.
module gnrc_lzc_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [N-1:0]  vec_i,
  input  logic          mode_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
`ifdef GNRC_LZC_PIPE_THERM_EN
  ,
  output logic [N-1:0]  therm_o
`endif
);

  logic [N-1:0]  vec_lsb;
  logic [CW-1:0] cnt_in;
  logic          zero_in;

  logic [STAGES-1:0]         vld_q,  vld_d;
  logic [STAGES-1:0][CW-1:0] cnt_q,  cnt_d;
  logic [STAGES-1:0]         zero_q, zero_d;
  logic [STAGES-1:0]         take;

`ifdef GNRC_LZC_PIPE_THERM_EN
  logic [N-1:0]             therm_in;
  logic [STAGES-1:0][N-1:0] therm_q, therm_d;
`endif

  // Orient the vector so that the count always starts at bit 0.
  always_comb begin
    vec_lsb = vec_i;
    for (int i = 0; i < N; i++) begin
      vec_lsb[i] = mode_i ? vec_i[i] : vec_i[N-1-i];
    end
  end

  always_comb begin
    cnt_in = CW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_lsb[i]) begin
        cnt_in = CW'(i);
      end
    end
  end

  assign zero_in = ~|vec_i;

`ifdef GNRC_LZC_PIPE_THERM_EN
  assign therm_in = ~({N{1'b1}} << cnt_in);
`endif

  // take[k]: slot k can be written this cycle (empty, or its word moves on).
  always_comb begin : take_chain
    logic down;
    down = ready_i;
    take = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = ~vld_q[k] | down;
      down    = take[k];
    end
  end

  assign ready_o = take[0];

  always_comb begin
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
`ifdef GNRC_LZC_PIPE_THERM_EN
    therm_d = therm_q;
`endif
    if (flush_i) begin
      vld_d = '0;
    end else begin
      if (take[0]) begin
        vld_d[0] = valid_i;
        if (valid_i) begin
          cnt_d[0]   = cnt_in;
          zero_d[0]  = zero_in;
`ifdef GNRC_LZC_PIPE_THERM_EN
          therm_d[0] = therm_in;
`endif
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (take[k]) begin
          vld_d[k] = vld_q[k-1];
          if (vld_q[k-1]) begin
            cnt_d[k]   = cnt_q[k-1];
            zero_d[k]  = zero_q[k-1];
`ifdef GNRC_LZC_PIPE_THERM_EN
            therm_d[k] = therm_q[k-1];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= '0;
`ifdef GNRC_LZC_PIPE_THERM_EN
      therm_q <= '0;
`endif
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
`ifdef GNRC_LZC_PIPE_THERM_EN
      therm_q <= therm_d;
`endif
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign cnt_o   = cnt_q[STAGES-1];
  assign zero_o  = zero_q[STAGES-1];
`ifdef GNRC_LZC_PIPE_THERM_EN
  assign therm_o = therm_q[STAGES-1];
`endif

endmodule

// File: tb/tb_gnrc_lzc_pipe.sv
// Bench for gnrc_lzc_pipe at N=8, STAGES=2; therm_o is checked when GNRC_LZC_PIPE_THERM_EN is defined.
module tb_gnrc_lzc_pipe;

  logic       clk = 1'b0;
  logic       rst_n, flush, vld_in, rdy_out, mode, vld_out, rdy_in, zero;
  logic [7:0] vec;
  logic [3:0] cnt;
  logic [7:0] therm;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [7:0] v; bit m;} word_t;
  word_t sb[$];
  word_t w;

  gnrc_lzc_pipe #(.N(8), .STAGES(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .valid_i (vld_in),
    .ready_o (rdy_out),
    .vec_i   (vec),
    .mode_i  (mode),
    .valid_o (vld_out),
    .ready_i (rdy_in),
    .cnt_o   (cnt),
    .zero_o  (zero)
`ifdef GNRC_LZC_PIPE_THERM_EN
    ,
    .therm_o (therm)
`endif
  );

`ifndef GNRC_LZC_PIPE_THERM_EN
  assign therm = 8'h00;
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Zeros counted from the MSB (m=0) or from the LSB (m=1).
  function automatic int ref_cnt(input logic [7:0] v, input bit m);
    int n = 0;
    while (n < 8 && v[m ? n : 7 - n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [7:0] ref_therm(input int c);
    logic [8:0] t = (9'd1 << c) - 9'd1;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] v, input bit m);
    int c = ref_cnt(v, m);
    chk({tag, "_valid"}, {31'd0, vld_out}, 32'd1);
    chk({tag, "_cnt"}, {28'd0, cnt}, c);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (v == 8'h00)});
`ifdef GNRC_LZC_PIPE_THERM_EN
    chk({tag, "_therm"}, {24'd0, therm}, {24'd0, ref_therm(c)});
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles while a word is offered.
    rst_n = 1'b0; flush = 1'b0; vld_in = 1'b1; vec = 8'h01; mode = 1'b0; rdy_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_valid", {31'd0, vld_out}, 32'd0);
      chk("rst_cnt", {28'd0, cnt}, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_therm", {24'd0, therm}, 32'd0);
    end
    rst_n = 1'b1; vld_in = 1'b0;
    #1 chk("rst_ready", {31'd0, rdy_out}, 32'd1);

    // Counting in both modes, non-zero and all-zero vectors.
    vld_in = 1'b1; vec = 8'h28; mode = 1'b0;
    tick;
    chk("lat_early", {31'd0, vld_out}, 32'd0);
    vec = 8'h28; mode = 1'b1;
    tick;
    chk_res("clz28", 8'h28, 1'b0);
    vec = 8'h00; mode = 1'b0;
    tick;
    chk_res("ctz28", 8'h28, 1'b1);
    vec = 8'h00; mode = 1'b1;
    tick;
    chk_res("clz00", 8'h00, 1'b0);
    vld_in = 1'b0;
    tick;
    chk_res("ctz00", 8'h00, 1'b1);
    tick;
    chk("drain_valid", {31'd0, vld_out}, 32'd0);

    // Backpressure: two words fill the pipe, the rest wait.
    rdy_in = 1'b0; mode = 1'b0; vld_in = 1'b1; vec = 8'h80;
    #1 chk("bp_rdy0", {31'd0, rdy_out}, 32'd1);
    tick;
    vec = 8'h10;
    #1 chk("bp_rdy1", {31'd0, rdy_out}, 32'd1);
    tick;
    vec = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_full", {31'd0, rdy_out}, 32'd0);
      chk_res("bp_hold", 8'h80, 1'b0);
      tick;
    end
    rdy_in = 1'b1;
    #1 chk("bp_release", {31'd0, rdy_out}, 32'd1);
    chk_res("bp_w0", 8'h80, 1'b0);
    tick;
    vec = 8'h00;
    #1 chk_res("bp_w1", 8'h10, 1'b0);
    tick;
    vld_in = 1'b0;
    #1 chk_res("bp_w2", 8'h02, 1'b0);
    tick;
    chk_res("bp_w3", 8'h00, 1'b0);
    tick;
    chk("bp_empty", {31'd0, vld_out}, 32'd0);

    // Flush with both slots full and a word offered.
    rdy_in = 1'b0; vld_in = 1'b1; vec = 8'h40;
    tick;
    vec = 8'h04;
    tick;
    chk_res("fl_full", 8'h40, 1'b0);
    flush = 1'b1; vec = 8'h01;
    tick;
    flush = 1'b0; vld_in = 1'b0;
    #1 chk("fl_valid", {31'd0, vld_out}, 32'd0);
    chk("fl_ready", {31'd0, rdy_out}, 32'd1);
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fl_gone", {31'd0, vld_out}, 32'd0);
    end

    // Reset mid-operation discards in-flight words.
    rdy_in = 1'b0; vld_in = 1'b1; vec = 8'h20;
    tick;
    tick;
    rst_n = 1'b0; vld_in = 1'b0;
    tick;
    rst_n = 1'b1; rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mrst_valid", {31'd0, vld_out}, 32'd0);
    end
    chk("mrst_cnt", {28'd0, cnt}, 32'd0);

    // Throughput: 16 random words back to back.
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        vld_in = 1'b1;
        w.v = 8'($urandom);
        if ($urandom_range(0, 3) == 0) w.v = 8'h00;
        w.m = 1'($urandom);
        vec = w.v; mode = w.m;
        sb.push_back(w);
        #1 chk("tp_ready", {31'd0, rdy_out}, 32'd1);
      end else begin
        vld_in = 1'b0;
      end
      tick;
      chk("tp_valid", {31'd0, vld_out}, {31'd0, (i >= 1 && i <= 16)});
      if (vld_out === 1'b1 && sb.size() > 0) begin
        w = sb.pop_front();
        chk_res("tp", w.v, w.m);
      end
    end
    chk("tp_all_out", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnrc_lzc_pipe.md
GNRC_LZC_PIPE -- requirements
Module: gnrc_lzc_pipe

Interface
REQ-001 SHALL have parameter N, default 8, meaning input vector width, legal range >= 2.
REQ-002 SHALL have parameter STAGES, default 2, meaning number of register slots, legal range 1..4.
REQ-003 SHALL derive localparam CW = $clog2(N+1), the count width.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port flush_i  input  1  discard all in-flight words.
REQ-007 SHALL have port valid_i  input  1  input word valid.
REQ-008 SHALL have port ready_o  output  1  block can accept a word.
REQ-009 SHALL have port vec_i  input  N  input vector.
REQ-010 SHALL have port mode_i  input  1  0 = count leading zeros from bit N-1 down; 1 = count trailing zeros from bit 0 up.
REQ-011 SHALL have port valid_o  output  1  result valid.
REQ-012 SHALL have port ready_i  input  1  consumer accepts the result.
REQ-013 SHALL have port cnt_o  output  CW  binary zero count, 0..N.
REQ-014 SHALL have port zero_o  output  1  input word was all zeros.

Function
REQ-015 SHALL count consecutive zeros of vec_i from the end selected by mode_i, as sampled at input transfer; an all-zero vec_i SHALL yield cnt = N and zero = 1, otherwise zero = 0.
REQ-016 SHALL compute the count combinationally on the input side and register it into slot 0; slots 1..STAGES-1 only carry results.
REQ-017 SHALL define an input transfer as valid_i & ready_o and an output transfer as valid_o & ready_i.
REQ-018 SHALL implement an elastic pipeline: slot k advances when slot k+1 is empty or advancing; the last slot advances on an output transfer.
REQ-019 SHALL drive ready_o = (slot 0 empty) | (slot 0 advancing), combinationally, with no dependence on valid_i.
REQ-020 SHALL give a latency of exactly STAGES cycles from input transfer to valid_o when not stalled.
REQ-021 SHALL sustain one transfer per cycle when valid_i and ready_i are held high.
REQ-022 SHALL hold valid_o, cnt_o and zero_o stable while valid_o = 1 and ready_i = 0.
REQ-023 SHALL deliver results in input order, with no loss and no duplication.
REQ-024 SHALL, on flush_i = 1, clear every slot's valid bit at the next edge.
REQ-025 SHALL drop an input transfer that occurs in the same cycle as flush_i; flush_i takes priority over all advances.
REQ-026 SHALL leave payload registers unchanged when their slot is not loaded.

Reset
REQ-027 SHALL, while rst_ni = 0 at a clock edge, clear all slot valid bits and all payload registers to 0, regardless of valid_i, ready_i or flush_i.
REQ-028 SHALL present after reset: valid_o = 0, cnt_o = 0, zero_o = 0, ready_o = 1 (and therm_o = 0 when present).
REQ-029 SHALL discard any in-flight words on reset mid-operation; none SHALL appear after rst_ni returns high.

Configuration
REQ-030 SHALL, when macro GNRC_LZC_PIPE_THERM_EN is defined, add port therm_o  output  N, carried alongside cnt_o.
REQ-031 therm_o bit k SHALL be 1 iff k < cnt; all-zero input gives all ones; it obeys the same stability and reset rules as cnt_o.
REQ-032 SHALL, without GNRC_LZC_PIPE_THERM_EN, omit therm_o and its registers; all other behaviour SHALL be identical.

Verification (N = 8, STAGES = 2, GNRC_LZC_PIPE_THERM_EN defined)
REQ-033 Reset: rst_ni = 0 for 2 cycles with valid_i = 1 and vec_i = 8'h01 -> valid_o = 0, cnt_o = 0, therm_o = 0 throughout; ready_o = 1 after release.
REQ-034 Count: vec_i = 8'h28, mode_i = 0 -> 2 cycles later cnt_o = 2, zero_o = 0, therm_o = 8'h03. Same vector with mode_i = 1 -> cnt_o = 3, therm_o = 8'h07.
REQ-035 All-zero: vec_i = 8'h00 in either mode -> cnt_o = 8, zero_o = 1, therm_o = 8'hFF.
REQ-036 Backpressure: offer 4 words with ready_i = 0 -> ready_o falls after 2 accepted and outputs hold stable. Then raise ready_i -> the 2 accepted words emerge in order, followed by the remaining 2 with no gaps.
REQ-037 Flush: with both slots full, assert flush_i with valid_i = 1 -> next cycle valid_o = 0 and ready_o = 1; none of the 3 affected words ever appears.
REQ-038 Throughput: 16 random words with valid_i = ready_i = 1 -> 16 results on consecutive cycles, matching a reference model.
